// File: rtl/ip_pkg.sv
// ---------------------------------------------------------------------------
// ip_pkg -- constants, FSM encoding and header record shared by the IPv4
// receive path (ip_rx and ip_chksum_acc).
//
// Contents:
//   P_TYPE_IP / P_TYPE_UDP / P_TYPE_ICMP  EtherType and protocol numbers
//   P_IP_HDR_LEN                          fixed header length (IHL = 5)
//   ST_*                                  receive FSM state encoding
//   ip_hdr_t                              header fields kept for the decision
//   fold_sum()                            ones-complement fold of a 32-bit sum
// ---------------------------------------------------------------------------
package ip_pkg;

    localparam logic [15:0] P_TYPE_IP    = 16'h0800;
    localparam logic [7:0]  P_TYPE_UDP   = 8'd17;
    localparam logic [7:0]  P_TYPE_ICMP  = 8'd1;
    localparam logic [15:0] P_IP_HDR_LEN = 16'd20;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HEADER  = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;

    // Only the header fields the accept decision or the outputs need.
    // frag holds MF (bit 13) and the fragment offset; DF and the reserved bit
    // play no part in the decision. dst_hi holds destination bytes 16..18;
    // byte 19 is compared straight off the bus.
    typedef struct packed {
        logic [7:0]  ver_ihl;
        logic [15:0] tot_len;
        logic [13:0] frag;
        logic [7:0]  proto;
        logic [31:0] src;
        logic [23:0] dst_hi;
    } ip_hdr_t;

    // Two folds are enough: after the first the carry is at most one bit and
    // adding it back into a value <= 16'hFFFE cannot carry again.
    function automatic logic [15:0] fold_sum(input logic [31:0] sum);
        logic [16:0] s1;
        logic [16:0] s2;
        s1 = {1'b0, sum[15:0]} + {1'b0, sum[31:16]};
        s2 = {1'b0, s1[15:0]} + {16'd0, s1[16]};
        return s2[15:0];
    endfunction

endpackage

// File: rtl/ip_chksum_acc.sv
// ---------------------------------------------------------------------------
// ip_chksum_acc -- IPv4 header checksum accumulator.
//
// Adds big-endian 16-bit words into a 32-bit running sum and presents the
// folded 16-bit result. The outputs reflect the sum *including* the word on
// i_word this cycle, so the caller can decide on the final header word in
// the same cycle it arrives.
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst         synchronous active-high reset
//   i_clear       restart the sum at zero (has priority over i_word_valid)
//   i_word_valid  add i_word this cycle
//   i_word        16-bit header word
//   o_sum         folded sum including the current word
//   o_valid       1 when o_sum == 16'hFFFF (checksum verifies)
// ---------------------------------------------------------------------------
module ip_chksum_acc
    import ip_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_word_valid,
    input  logic [15:0] i_word,
    output logic [15:0] o_sum,
    output logic        o_valid
);

    logic [31:0] acc_q;
    logic [31:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (i_clear) begin
            acc_d = 32'd0;
        end else if (i_word_valid) begin
            acc_d = acc_q + {16'd0, i_word};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q <= 32'd0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign o_sum   = fold_sum(acc_d);
    assign o_valid = (o_sum == 16'hFFFF);

endmodule

// File: rtl/ip_rx.sv
// ---------------------------------------------------------------------------
// ip_rx -- IPv4 receive filter.
//
// Parses the fixed 20-byte IPv4 header from a byte stream, checks EtherType,
// version/IHL, fragmentation, length, header checksum, protocol (ICMP/UDP)
// and destination address, then forwards the payload with one cycle of
// latency. Rejected packets produce a single o_drop pulse; Ethernet padding
// beyond the IP total length is swallowed.
//
// Ports:
//   i_clk, i_rst          clock / synchronous active-high reset
//   i_local_ip(_valid)    runtime load of the local address
//   i_mac_type            EtherType of the current frame
//   i_mac_data/last/valid frame byte stream, IP header first
//   o_recv_data/last/valid payload stream
//   o_recv_type           IP protocol of the accepted packet
//   o_recv_len            payload length (total length - 20)
//   o_src_ip              source address of the accepted packet
//   o_recv_err            with o_recv_last when the frame was truncated
//   o_drop                one-cycle pulse per rejected packet
// ---------------------------------------------------------------------------
module ip_rx
    import ip_pkg::*;
#(
    parameter logic [31:0] P_LOCAL_IP = {8'd192, 8'd168, 8'd1, 8'd1}
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_local_ip,
    input  logic        i_local_ip_valid,
    input  logic [15:0] i_mac_type,
    input  logic [7:0]  i_mac_data,
    input  logic        i_mac_last,
    input  logic        i_mac_valid,
    output logic [7:0]  o_recv_data,
    output logic [7:0]  o_recv_type,
    output logic [15:0] o_recv_len,
    output logic [31:0] o_src_ip,
    output logic        o_recv_last,
    output logic        o_recv_valid,
    output logic        o_recv_err,
    output logic        o_drop
);

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;          // index of the frame byte on the bus
    logic        valid_q;
    logic [31:0] local_ip_q, local_ip_d;
    ip_hdr_t     hdr_q, hdr_d;
    logic [7:0]  hi_q, hi_d;            // high byte of the header word in flight

    logic [7:0]  recv_data_q, recv_data_d;
    logic [7:0]  recv_type_q, recv_type_d;
    logic [15:0] recv_len_q, recv_len_d;
    logic [31:0] src_ip_q, src_ip_d;
    logic        recv_last_q, recv_last_d;
    logic        recv_valid_q, recv_valid_d;
    logic        recv_err_q, recv_err_d;
    logic        drop_q, drop_d;

    logic        frame_start;
    logic        hdr_en;
    logic [15:0] idx;
    logic        word_valid;
    logic [15:0] word;
    logic        chk_clear;
    logic [15:0] chk_sum;
    logic        chk_valid;
    logic        chk_ok;
    logic [31:0] dst_ip;
    logic        hdr_done;
    logic        pay_end;
    logic        accept;

    // -----------------------------------------------------------------------
    // Header byte steering
    // -----------------------------------------------------------------------
    assign frame_start = i_mac_valid & ~valid_q;

    // Byte 0 arrives while still in IDLE, so it is indexed explicitly.
    assign hdr_en = ((state_q == ST_IDLE) && frame_start) ||
                    ((state_q == ST_HEADER) && i_mac_valid);
    assign idx    = (state_q == ST_IDLE) ? 16'd0 : cnt_q;

    // A word completes on every odd header byte: {previous byte, this byte}.
    assign word_valid = hdr_en & idx[0];
    assign word       = {hi_q, i_mac_data};
    assign chk_clear  = (state_q == ST_IDLE) && frame_start;

    ip_chksum_acc u_chksum (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (chk_clear),
        .i_word_valid (word_valid),
        .i_word       (word),
        .o_sum        (chk_sum),
        .o_valid      (chk_valid)
    );

    assign chk_ok = chk_valid && (chk_sum == 16'hFFFF);

    always_comb begin
        hdr_d = hdr_q;
        hi_d  = hi_q;
        if (hdr_en) begin
            if (!idx[0]) begin
                hi_d = i_mac_data;
            end
            case (idx)
                16'd0:   hdr_d.ver_ihl       = i_mac_data;
                16'd2:   hdr_d.tot_len[15:8] = i_mac_data;
                16'd3:   hdr_d.tot_len[7:0]  = i_mac_data;
                16'd6:   hdr_d.frag[13:8]    = i_mac_data[5:0];
                16'd7:   hdr_d.frag[7:0]     = i_mac_data;
                16'd9:   hdr_d.proto         = i_mac_data;
                16'd12:  hdr_d.src[31:24]    = i_mac_data;
                16'd13:  hdr_d.src[23:16]    = i_mac_data;
                16'd14:  hdr_d.src[15:8]     = i_mac_data;
                16'd15:  hdr_d.src[7:0]      = i_mac_data;
                16'd16:  hdr_d.dst_hi[23:16] = i_mac_data;
                16'd17:  hdr_d.dst_hi[15:8]  = i_mac_data;
                16'd18:  hdr_d.dst_hi[7:0]   = i_mac_data;
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Accept decision, evaluated while header byte 19 is on the bus
    // -----------------------------------------------------------------------
    assign dst_ip   = {hdr_q.dst_hi, i_mac_data};
    assign hdr_done = (state_q == ST_HEADER) && (cnt_q == P_IP_HDR_LEN - 16'd1);
    assign pay_end  = (cnt_q == hdr_q.tot_len - 16'd1);

    assign accept = (i_mac_type == P_TYPE_IP) &&
                    (hdr_q.ver_ihl == 8'h45) &&
                    (hdr_q.frag == 14'd0) &&
                    (hdr_q.tot_len > P_IP_HDR_LEN) &&
                    chk_ok &&
                    ((hdr_q.proto == P_TYPE_UDP) || (hdr_q.proto == P_TYPE_ICMP)) &&
                    ((dst_ip == local_ip_q) || (dst_ip == 32'hFFFF_FFFF));

    // -----------------------------------------------------------------------
    // Receive FSM and registered outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        local_ip_d   = local_ip_q;
        recv_data_d  = recv_data_q;
        recv_type_d  = recv_type_q;
        recv_len_d   = recv_len_q;
        src_ip_d     = src_ip_q;
        recv_valid_d = 1'b0;
        recv_last_d  = 1'b0;
        recv_err_d   = 1'b0;
        drop_d       = 1'b0;

        if (i_local_ip_valid) begin
            local_ip_d = i_local_ip;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    if (i_mac_last) begin
                        drop_d = 1'b1;  // one-byte frame, header never completes
                    end else begin
                        state_d = ST_HEADER;
                        cnt_d   = 16'd1;
                    end
                end
            end

            ST_HEADER: begin
                if (!i_mac_valid) begin
                    state_d = ST_IDLE;  // broken stream: abandon quietly
                end else if (i_mac_last) begin
                    state_d = ST_IDLE;  // frame shorter than a header plus payload
                    drop_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (hdr_done) begin
                        if (accept) begin
                            state_d     = ST_PAYLOAD;
                            recv_type_d = hdr_q.proto;
                            recv_len_d  = hdr_q.tot_len - P_IP_HDR_LEN;
                            src_ip_d    = hdr_q.src;
                        end else begin
                            state_d = ST_DISCARD;
                            drop_d  = 1'b1;
                        end
                    end
                end
            end

            ST_PAYLOAD: begin
                if (!i_mac_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    recv_valid_d = 1'b1;
                    recv_data_d  = i_mac_data;
                    cnt_d        = cnt_q + 16'd1;
                    if (pay_end) begin
                        recv_last_d = 1'b1;
                        // Anything after total length is Ethernet padding.
                        state_d     = i_mac_last ? ST_IDLE : ST_DISCARD;
                    end else if (i_mac_last) begin
                        recv_last_d = 1'b1;
                        recv_err_d  = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end

            ST_DISCARD: begin
                if (!i_mac_valid || i_mac_last) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_IDLE) begin
            cnt_d = 16'd0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 16'd0;
            // Track the bus even in reset so a frame already in flight is not
            // mistaken for a new start once reset is released.
            valid_q      <= i_mac_valid;
            local_ip_q   <= P_LOCAL_IP;
            hdr_q        <= '0;
            hi_q         <= 8'd0;
            recv_data_q  <= 8'd0;
            recv_type_q  <= 8'd0;
            recv_len_q   <= 16'd0;
            src_ip_q     <= 32'd0;
            recv_last_q  <= 1'b0;
            recv_valid_q <= 1'b0;
            recv_err_q   <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            valid_q      <= i_mac_valid;
            local_ip_q   <= local_ip_d;
            hdr_q        <= hdr_d;
            hi_q         <= hi_d;
            recv_data_q  <= recv_data_d;
            recv_type_q  <= recv_type_d;
            recv_len_q   <= recv_len_d;
            src_ip_q     <= src_ip_d;
            recv_last_q  <= recv_last_d;
            recv_valid_q <= recv_valid_d;
            recv_err_q   <= recv_err_d;
            drop_q       <= drop_d;
        end
    end

    assign o_recv_data  = recv_data_q;
    assign o_recv_type  = recv_type_q;
    assign o_recv_len   = recv_len_q;
    assign o_src_ip     = src_ip_q;
    assign o_recv_last  = recv_last_q;
    assign o_recv_valid = recv_valid_q;
    assign o_recv_err   = recv_err_q;
    assign o_drop       = drop_q;

endmodule

// File: tb/tb_ip_rx.sv
// ---------------------------------------------------------------------------
// tb_ip_rx -- self-checking bench for ip_rx. Each test builds a frame, pushes
// the payload beats it expects onto a scoreboard while driving, and a
// negedge monitor pops and compares every beat the DUT produces.
// ---------------------------------------------------------------------------
module tb_ip_rx;

    localparam logic [31:0] MY_IP   = 32'hC0A8_0101;
    localparam logic [31:0] ALT_IP  = 32'hC0A8_0107;
    localparam logic [31:0] PEER_IP = 32'hC0A8_0164;
    localparam logic [31:0] BCAST   = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_local_ip = 32'd0;
    logic        i_local_ip_valid = 1'b0;
    logic [15:0] i_mac_type = 16'h0800;
    logic [7:0]  i_mac_data = 8'd0;
    logic        i_mac_last = 1'b0;
    logic        i_mac_valid = 1'b0;
    logic [7:0]  o_recv_data;
    logic [7:0]  o_recv_type;
    logic [15:0] o_recv_len;
    logic [31:0] o_src_ip;
    logic        o_recv_last;
    logic        o_recv_valid;
    logic        o_recv_err;
    logic        o_drop;

    always #5 clk = ~clk;

    ip_rx dut (
        .i_clk            (clk),
        .i_rst            (i_rst),
        .i_local_ip       (i_local_ip),
        .i_local_ip_valid (i_local_ip_valid),
        .i_mac_type       (i_mac_type),
        .i_mac_data       (i_mac_data),
        .i_mac_last       (i_mac_last),
        .i_mac_valid      (i_mac_valid),
        .o_recv_data      (o_recv_data),
        .o_recv_type      (o_recv_type),
        .o_recv_len       (o_recv_len),
        .o_src_ip         (o_src_ip),
        .o_recv_last      (o_recv_last),
        .o_recv_valid     (o_recv_valid),
        .o_recv_err       (o_recv_err),
        .o_drop           (o_drop)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       err;
        int         cyc;
    } beat_t;

    beat_t      sb[$];
    logic [7:0] frm[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         beat_cnt = 0;
    int         drop_cnt = 0;
    logic [7:0]  exp_type = 8'd0;
    logic [15:0] exp_len = 16'd0;
    logic [31:0] exp_src = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every beat must match the oldest expected entry,
    // including the cycle it was due (one cycle after its input byte).
    always @(negedge clk) begin : mon
        beat_t e;
        if (o_drop === 1'b1) drop_cnt++;
        if (o_recv_valid === 1'b1) begin
            beat_cnt++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL beat_unexpected: got data %h last %b, required no beat",
                         o_recv_data, o_recv_last);
            end else begin
                e = sb.pop_front();
                if (o_recv_data !== e.data || o_recv_last !== e.last ||
                    o_recv_err !== e.err || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL beat: got data %h last %b err %b cyc %0d, required data %h last %b err %b cyc %0d",
                             o_recv_data, o_recv_last, o_recv_err, cyc,
                             e.data, e.last, e.err, e.cyc);
                end
                n_cmp++;
                if (o_recv_type !== exp_type || o_recv_len !== exp_len || o_src_ip !== exp_src) begin
                    n_fail++;
                    $display("FAIL beat_meta: got type %0d len %0d src %h, required type %0d len %0d src %h",
                             o_recv_type, o_recv_len, o_src_ip, exp_type, exp_len, exp_src);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Header with a correct checksum, then n_pay bytes 01, 02, ...
    task automatic make_frame(input logic [7:0] proto, input logic [15:0] tot,
                              input logic [31:0] src, input logic [31:0] dst, input int n_pay);
        logic [7:0]  h[20];
        logic [31:0] s;
        logic [15:0] c;
        h[0] = 8'h45; h[1] = 8'h00; h[2] = tot[15:8]; h[3] = tot[7:0];
        h[4] = 8'h12; h[5] = 8'h34; h[6] = 8'h40; h[7] = 8'h00;
        h[8] = 8'd64; h[9] = proto; h[10] = 8'h00; h[11] = 8'h00;
        h[12] = src[31:24]; h[13] = src[23:16]; h[14] = src[15:8]; h[15] = src[7:0];
        h[16] = dst[31:24]; h[17] = dst[23:16]; h[18] = dst[15:8]; h[19] = dst[7:0];
        s = 32'd0;
        for (int i = 0; i < 20; i += 2) s = s + {16'd0, h[i], h[i+1]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        c = ~s[15:0];
        h[10] = c[15:8];
        h[11] = c[7:0];
        frm.delete();
        for (int i = 0; i < 20; i++) frm.push_back(h[i]);
        for (int k = 0; k < n_pay; k++) frm.push_back(8'(k + 1));
    endtask

    task automatic drive_byte(input logic [7:0] d, input logic last, input logic rst);
        @(posedge clk); #1;
        i_mac_valid = 1'b1;
        i_mac_data  = d;
        i_mac_last  = last;
        i_rst       = rst;
    endtask

    task automatic idle_bus();
        @(posedge clk); #1;
        i_mac_valid = 1'b0;
        i_mac_last  = 1'b0;
        i_mac_data  = 8'd0;
        i_rst       = 1'b0;
    endtask

    // Drive frm; the first n_exp payload bytes are expected as beats, the
    // last of them flagged (with err if exp_err). Then wait for the drain.
    task automatic send_frame(input logic [15:0] mtype, input int n_exp, input bit exp_err);
        int sz;
        sz = frm.size();
        i_mac_type = mtype;
        for (int i = 0; i < sz; i++) begin
            drive_byte(frm[i], (i == sz - 1), 1'b0);
            if (i >= 20 && i - 20 < n_exp)
                sb.push_back('{data: frm[i], last: (i - 20 == n_exp - 1),
                               err: (exp_err && (i - 20 == n_exp - 1)), cyc: cyc + 1});
        end
        idle_bus();
        repeat (3) @(negedge clk);
        for (int w = 0; w < 20 && sb.size() != 0; w++) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d beats outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 i_rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({o_recv_valid, o_recv_last, o_recv_err, o_drop} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 0000",
                     {o_recv_valid, o_recv_last, o_recv_err, o_drop});
        end
        n_cmp++;
        if ({o_recv_data, o_recv_type, o_recv_len, o_src_ip} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_fields: got data %h type %h len %h src %h, required all 0",
                     o_recv_data, o_recv_type, o_recv_len, o_src_ip);
        end
    endtask

    task automatic test_udp();
        int b0, d0;
        b0 = beat_cnt; d0 = drop_cnt;
        exp_type = 8'd17; exp_len = 16'd8; exp_src = PEER_IP;
        make_frame(8'd17, 16'd28, PEER_IP, MY_IP, 8);
        send_frame(16'h0800, 8, 1'b0);
        n_cmp++;
        if (beat_cnt - b0 != 8 || drop_cnt - d0 != 0) begin
            n_fail++;
            $display("FAIL udp_counts: got beats %0d drops %0d, required 8 and 0",
                     beat_cnt - b0, drop_cnt - d0);
        end
        n_cmp++;
        if (o_recv_len !== 16'd8 || o_recv_type !== 8'd17) begin
            n_fail++;
            $display("FAIL udp_meta_hold: got len %0d type %0d, required 8 and 17",
                     o_recv_len, o_recv_type);
        end
    endtask

    task automatic test_bad_chksum();
        int b0, d0;
        b0 = beat_cnt; d0 = drop_cnt;
        make_frame(8'd17, 16'd28, PEER_IP, MY_IP, 8);
        frm[10] = ~frm[10];
        send_frame(16'h0800, 0, 1'b0);
        n_cmp++;
        if (beat_cnt - b0 != 0 || drop_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL bad_chksum: got beats %0d drops %0d, required 0 and 1",
                     beat_cnt - b0, drop_cnt - d0);
        end
    endtask

    task automatic test_icmp_pad();
        int b0, d0;
        b0 = beat_cnt; d0 = drop_cnt;
        exp_type = 8'd1; exp_len = 16'd9; exp_src = PEER_IP;
        make_frame(8'd1, 16'd29, PEER_IP, MY_IP, 46);
        send_frame(16'h0800, 9, 1'b0);
        n_cmp++;
        if (beat_cnt - b0 != 9 || drop_cnt - d0 != 0) begin
            n_fail++;
            $display("FAIL icmp_pad: got beats %0d drops %0d, required 9 and 0",
                     beat_cnt - b0, drop_cnt - d0);
        end
    endtask

    task automatic test_local_ip();
        int b0, d0;
        b0 = beat_cnt; d0 = drop_cnt;
        make_frame(8'd17, 16'd28, PEER_IP, ALT_IP, 8);
        send_frame(16'h0800, 0, 1'b0);
        n_cmp++;
        if (beat_cnt - b0 != 0 || drop_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL foreign_dst: got beats %0d drops %0d, required 0 and 1",
                     beat_cnt - b0, drop_cnt - d0);
        end
        @(posedge clk); #1;
        i_local_ip = ALT_IP; i_local_ip_valid = 1'b1;
        @(posedge clk); #1;
        i_local_ip_valid = 1'b0; i_local_ip = 32'd0;
        b0 = beat_cnt; d0 = drop_cnt;
        exp_type = 8'd17; exp_len = 16'd8; exp_src = PEER_IP;
        make_frame(8'd17, 16'd28, PEER_IP, ALT_IP, 8);
        send_frame(16'h0800, 8, 1'b0);
        n_cmp++;
        if (beat_cnt - b0 != 8 || drop_cnt - d0 != 0) begin
            n_fail++;
            $display("FAIL loaded_dst: got beats %0d drops %0d, required 8 and 0",
                     beat_cnt - b0, drop_cnt - d0);
        end
        b0 = beat_cnt; d0 = drop_cnt;
        exp_src = 32'h0A00_0005; exp_len = 16'd4;
        make_frame(8'd17, 16'd24, 32'h0A00_0005, BCAST, 4);
        send_frame(16'h0800, 4, 1'b0);
        n_cmp++;
        if (beat_cnt - b0 != 4 || drop_cnt - d0 != 0 || o_src_ip !== 32'h0A00_0005) begin
            n_fail++;
            $display("FAIL broadcast: got beats %0d drops %0d src %h, required 4, 0, 0a000005",
                     beat_cnt - b0, drop_cnt - d0, o_src_ip);
        end
    endtask

    task automatic test_truncated();
        int b0, d0;
        b0 = beat_cnt; d0 = drop_cnt;
        exp_type = 8'd17; exp_len = 16'd80; exp_src = PEER_IP;
        make_frame(8'd17, 16'd100, PEER_IP, BCAST, 30);
        send_frame(16'h0800, 30, 1'b1);
        n_cmp++;
        if (beat_cnt - b0 != 30 || drop_cnt - d0 != 0) begin
            n_fail++;
            $display("FAIL truncated: got beats %0d drops %0d, required 30 and 0",
                     beat_cnt - b0, drop_cnt - d0);
        end
    endtask

    task automatic test_drops();
        int d0, b0;
        b0 = beat_cnt; d0 = drop_cnt;
        make_frame(8'd17, 16'd28, PEER_IP, MY_IP, 8);
        send_frame(16'h0806, 0, 1'b0);                // not IPv4
        make_frame(8'd6, 16'd28, PEER_IP, MY_IP, 8);
        send_frame(16'h0800, 0, 1'b0);                // TCP
        make_frame(8'd17, 16'd20, PEER_IP, MY_IP, 26);
        send_frame(16'h0800, 0, 1'b0);                // no payload
        make_frame(8'd17, 16'd28, PEER_IP, MY_IP, 0);
        while (frm.size() > 10) void'(frm.pop_back());
        send_frame(16'h0800, 0, 1'b0);                // ends inside header
        n_cmp++;
        if (beat_cnt - b0 != 0 || drop_cnt - d0 != 4) begin
            n_fail++;
            $display("FAIL drop_cases: got beats %0d drops %0d, required 0 and 4",
                     beat_cnt - b0, drop_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        int b0, d0;
        b0 = beat_cnt; d0 = drop_cnt;
        exp_type = 8'd17; exp_len = 16'd8; exp_src = PEER_IP;
        make_frame(8'd17, 16'd28, PEER_IP, BCAST, 8);
        i_mac_type = 16'h0800;
        for (int i = 0; i < 28; i++) begin
            drive_byte(frm[i], (i == 27), (i == 23));
            if (i >= 20 && i <= 22)
                sb.push_back('{data: frm[i], last: 1'b0, err: 1'b0, cyc: cyc + 1});
            if (i == 24) begin
                @(negedge clk);
                n_cmp++;
                if ({o_recv_valid, o_recv_last, o_recv_data, o_recv_type, o_recv_len, o_src_ip} !== 66'd0) begin
                    n_fail++;
                    $display("FAIL reset_mid_outputs: got valid %b data %h type %h len %h src %h, required all 0",
                             o_recv_valid, o_recv_data, o_recv_type, o_recv_len, o_src_ip);
                end
            end
        end
        idle_bus();
        repeat (4) @(negedge clk);
        n_cmp++;
        if (beat_cnt - b0 != 3 || drop_cnt - d0 != 0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_counts: got beats %0d drops %0d pending %0d, required 3, 0, 0",
                     beat_cnt - b0, drop_cnt - d0, sb.size());
            sb.delete();
        end
        // Local address is back to its default, so MY_IP must be accepted.
        b0 = beat_cnt;
        make_frame(8'd17, 16'd28, PEER_IP, MY_IP, 8);
        send_frame(16'h0800, 8, 1'b0);
        n_cmp++;
        if (beat_cnt - b0 != 8) begin
            n_fail++;
            $display("FAIL reset_mid_next: got beats %0d, required 8", beat_cnt - b0);
        end
    endtask

    task automatic test_back_to_back();
        int b0, d0;
        b0 = beat_cnt; d0 = drop_cnt;
        exp_type = 8'd17; exp_len = 16'd3; exp_src = 32'h0102_0304;
        make_frame(8'd17, 16'd23, 32'h0102_0304, MY_IP, 3);
        send_frame(16'h0800, 3, 1'b0);
        exp_type = 8'd1; exp_len = 16'd5; exp_src = 32'h0506_0708;
        make_frame(8'd1, 16'd25, 32'h0506_0708, MY_IP, 5);
        send_frame(16'h0800, 5, 1'b0);
        n_cmp++;
        if (beat_cnt - b0 != 8 || drop_cnt - d0 != 0 || o_src_ip !== 32'h0506_0708) begin
            n_fail++;
            $display("FAIL back_to_back: got beats %0d drops %0d src %h, required 8, 0, 05060708",
                     beat_cnt - b0, drop_cnt - d0, o_src_ip);
        end
    endtask

    initial begin
        test_reset();
        test_udp();
        test_bad_chksum();
        test_icmp_pad();
        test_local_ip();
        test_truncated();
        test_drops();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
